// File: rtl/waveform_gen_if.sv
// Config/sample bundle between fabric logic (master) and waveform_gen (slave).
// The sync strobe exists only when WAVE_SYNC_EN is defined.
interface waveform_gen_if #(
  parameter int VAL_BITS  = 7,
  parameter int STEP_BITS = 16
);
  logic                 en;
  logic                 load;
`ifdef WAVE_SYNC_EN
  logic                 sync;
`endif
  logic [STEP_BITS-1:0] step;
  logic [1:0]           mode;
  logic [VAL_BITS-1:0]  duty;
  logic                 load_ack;
  logic [VAL_BITS-1:0]  val;
  logic                 wrap;

`ifdef WAVE_SYNC_EN
  modport master (output en, load, sync, step, mode, duty, input load_ack, val, wrap);
  modport slave  (input en, load, sync, step, mode, duty, output load_ack, val, wrap);
`else
  modport master (output en, load, step, mode, duty, input load_ack, val, wrap);
  modport slave  (input en, load, step, mode, duty, output load_ack, val, wrap);
`endif
endinterface

// File: rtl/waveform_gen.sv
// Phase-accumulator waveform source (saw up/down, triangle, square) with config
// applied at period boundaries. Define WAVE_SYNC_EN to add the phase-reset strobe.
module waveform_gen #(
  parameter int ACC_BITS  = 30,
  parameter int VAL_BITS  = 7,
  parameter int STEP_BITS = 16
) (
  input logic           clk,
  input logic           rst_n,
  waveform_gen_if.slave bus
);
  localparam logic [STEP_BITS-1:0] STEP_RST = {{(STEP_BITS-1){1'b0}}, 1'b1};
  localparam logic [VAL_BITS-1:0]  DUTY_RST = {1'b1, {(VAL_BITS-1){1'b0}}};
  localparam logic [VAL_BITS-1:0]  VAL_ONES = {VAL_BITS{1'b1}};
  localparam logic [VAL_BITS-1:0]  VAL_ZERO = {VAL_BITS{1'b0}};

  logic [ACC_BITS-1:0]  acc_r;
  logic [STEP_BITS-1:0] step_r;
  logic [1:0]           mode_r;
  logic [VAL_BITS-1:0]  duty_r;
  logic [STEP_BITS-1:0] pend_step_r;
  logic [1:0]           pend_mode_r;
  logic [VAL_BITS-1:0]  pend_duty_r;
  logic                 pend_r;
  logic [VAL_BITS-1:0]  val_r;
  logic                 wrap_r;
  logic                 ack_r;

  logic [ACC_BITS:0]    sum_s;
  logic                 carry_s;
  logic                 sync_s;
  logic                 apply_s;
  logic [VAL_BITS-1:0]  phase_s;
  logic [VAL_BITS-1:0]  tri_s;
  logic [VAL_BITS-1:0]  sample_s;

`ifdef WAVE_SYNC_EN
  assign sync_s = bus.sync;
`else
  assign sync_s = 1'b0;
`endif

  // Next-phase sum, boundary detection and sample shaping from the current phase.
  always_comb begin
    sum_s    = {1'b0, acc_r} + {{(ACC_BITS + 1 - STEP_BITS){1'b0}}, step_r};
    carry_s  = bus.en & sum_s[ACC_BITS];
    // Stopped or phase-reset accumulators have no mid-period glitch to avoid.
    apply_s  = pend_r & (carry_s | ~bus.en | sync_s);
    phase_s  = acc_r[ACC_BITS-1 -: VAL_BITS];
    tri_s    = acc_r[ACC_BITS-2 -: VAL_BITS];
    sample_s = VAL_ZERO;
    case (mode_r)
      2'b00:   sample_s = phase_s;
      2'b01:   sample_s = ~phase_s;
      2'b10:   sample_s = acc_r[ACC_BITS-1] ? ~tri_s : tri_s;
      2'b11:   sample_s = (phase_s < duty_r) ? VAL_ONES : VAL_ZERO;
      default: sample_s = VAL_ZERO;
    endcase
  end

  // Accumulator, registered outputs and pending/active config handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r       <= {ACC_BITS{1'b0}};
      step_r      <= STEP_RST;
      mode_r      <= 2'b00;
      duty_r      <= DUTY_RST;
      pend_step_r <= STEP_RST;
      pend_mode_r <= 2'b00;
      pend_duty_r <= DUTY_RST;
      pend_r      <= 1'b0;
      val_r       <= VAL_ZERO;
      wrap_r      <= 1'b0;
      ack_r       <= 1'b0;
    end else begin
      if (sync_s) begin
        acc_r  <= {ACC_BITS{1'b0}};
        wrap_r <= 1'b0;
      end else if (bus.en) begin
        acc_r  <= sum_s[ACC_BITS-1:0];
        wrap_r <= carry_s;
      end else begin
        wrap_r <= 1'b0;
      end

      val_r <= sample_s;
      ack_r <= apply_s;

      if (apply_s) begin
        step_r <= pend_step_r;
        mode_r <= pend_mode_r;
        duty_r <= pend_duty_r;
      end

      // A load coinciding with apply re-arms pending with the fresh values.
      if (bus.load) begin
        pend_step_r <= bus.step;
        pend_mode_r <= bus.mode;
        pend_duty_r <= bus.duty;
        pend_r      <= 1'b1;
      end else if (apply_s) begin
        pend_r <= 1'b0;
      end
    end
  end

  assign bus.val      = val_r;
  assign bus.wrap     = wrap_r;
  assign bus.load_ack = ack_r;
endmodule
